// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe
//   Two-stage AES SubBytes engine. Each beat carries LANES independent bytes
//   and its own forward/inverse mode flag; every lane is passed through the
//   FIPS-197 S-box (or its inverse) with no byte reordering.
//
// Ports
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   flush          : synchronous pipeline clear (beat_cnt untouched)
//   in_valid/in_ready, inv, D_in    : input beat handshake, mode, data
//   out_valid/out_ready, D_out      : output beat handshake and data
//   beat_cnt       : count of accepted input beats since reset (wraps)
//
// The S-box is computed arithmetically (GF(2^8) inverse plus affine map)
// rather than stored as a table. With INV_EN=0 the mode select is a constant
// zero, so the inverse path is pruned away by synthesis.
module sub_bytes_pipe #(
  parameter int LANES  = 4,
  parameter int INV_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 inv,
  input  logic [8*LANES-1:0]   D_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   D_out,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam int DATA_W = 8 * LANES;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < 6; i++) begin
      y = gf_mul(gf_mul(y, y), x);
    end
    return gf_mul(y, y);
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] s;
    y = gf_inv(x);
    for (int i = 0; i < 8; i++) begin
      s[i] = y[i] ^ y[(i + 4) % 8] ^ y[(i + 5) % 8] ^ y[(i + 6) % 8] ^ y[(i + 7) % 8];
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      t[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
    end
    return gf_inv(t ^ 8'h05);
  endfunction

  logic              vld_p1_q, vld_p1_d;
  logic              inv_p1_q, inv_p1_d;
  logic [DATA_W-1:0] data_p1_q, data_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic [DATA_W-1:0] data_p2_q, data_p2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              s1_adv;
  logic              s2_adv;
  logic              accept;
  logic              mode;
  logic [DATA_W-1:0] sub;

  always_comb begin
    s2_adv   = !vld_p2_q || out_ready;
    s1_adv   = !vld_p1_q || s2_adv;
    in_ready = s1_adv && !flush && !rst;
    accept   = in_valid && in_ready;

    mode = (INV_EN != 0) && inv_p1_q;
    sub  = '0;
    for (int i = 0; i < LANES; i++) begin
      sub[8*i +: 8] = mode ? sbox_inv(data_p1_q[8*i +: 8]) : sbox_fwd(data_p1_q[8*i +: 8]);
    end

    vld_p1_d  = vld_p1_q;
    inv_p1_d  = inv_p1_q;
    data_p1_d = data_p1_q;
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    cnt_d     = cnt_q;

    if (s1_adv) begin
      vld_p1_d  = in_valid;
      inv_p1_d  = inv;
      data_p1_d = D_in;
    end
    if (s2_adv) begin
      vld_p2_d  = vld_p1_q;
      data_p2_d = sub;
    end
    if (accept) cnt_d = cnt_q + CNT_W'(1);

    // A flush drops both in-flight beats; the refused input never enters.
    if (flush || rst) begin
      vld_p1_d = 1'b0;
      vld_p2_d = 1'b0;
    end
  end

  // ---- stage 1: capture input bytes and mode ----
  always_ff @(posedge clk) begin
    data_p1_q <= data_p1_d;
    inv_p1_q  <= inv_p1_d;
  end

  // ---- stage 2: substituted bytes, valids and beat counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      cnt_q     <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign D_out     = data_p2_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: doc/sub_bytes_pipe.md
# sub_bytes_pipe

Parametrised, pipelined AES SubBytes engine: applies the FIPS-197 S-box (or, when enabled, the inverse S-box) to LANES bytes per beat behind a valid/ready handshake. It succeeds the single-byte combinational S-box lookup and sits between the AddRoundKey stage and ShiftRows in the round datapath. The same instance can also serve the key schedule's SubWord when LANES=4.

## Interface
- LANES, 4, number of byte lanes per beat (1..16); data width = 8*LANES
- INV_EN, 1, 1 = inverse S-box available via `inv`; 0 = forward only, `inv` ignored
- CNT_W, 16, width of the accepted-beat counter
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline clear, same cycle effect as rst except `beat_cnt`
- in_valid  input  1  input beat present
- in_ready  output  1  engine can accept a beat this cycle
- inv  input  1  per-beat mode: 0 forward, 1 inverse (INV_EN=1 only)
- D_in  input  8*LANES  input bytes; lane i = D_in[8i+7:8i]
- out_valid  output  1  output beat present
- out_ready  input  1  downstream accepts output this cycle
- D_out  output  8*LANES  substituted bytes, lane-aligned with D_in
- beat_cnt  output  CNT_W  number of input beats accepted since reset

## Operation
- Two register stages: S1 captures D_in and inv; S2 holds the lane-wise S-box/inverse S-box of S1 and drives D_out/out_valid.
- Lane i of D_out = SBOX(lane i of D_in) if the beat's inv=0, else INV_SBOX(lane i). Lanes are independent; no byte reordering.
- When INV_EN=0, no inverse table is synthesised; all beats use the forward table.
- Handshake: a beat is accepted when in_valid && in_ready; delivered when out_valid && out_ready.
- s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
- On s2_adv: S2 loads S1 contents and s2_valid <= s1_valid. On s1_adv: S1 loads input and s1_valid <= in_valid.
- Stalled stages hold data and mode unchanged; D_out stable while out_valid && !out_ready.
- beat_cnt increments by 1 on each accepted beat; wraps modulo 2^CNT_W.
- flush: s1_valid, s2_valid <= 0; input offered in the flush cycle is not accepted (in_ready forced 0); beat_cnt unchanged.
- rst: as flush, plus beat_cnt <= 0 and D_out <= 0. rst has priority over flush.

## Timing
- Reset values: out_valid 0, D_out 0, beat_cnt 0, in_ready 0 during rst cycle, 1 the cycle after.
- Latency: beat accepted at edge N appears on D_out with out_valid=1 after edge N+1 (two edges, usable in cycle N+2 relative to acceptance cycle N).
- Throughput: one beat per cycle with out_ready held high.
- in_ready depends combinationally on out_ready (single-level); no combinational path from D_in to D_out.
- Back-pressure: with out_ready=0, pipeline absorbs exactly 2 beats, then in_ready=0 in the following cycle.
- Simultaneous output deliver and input accept in a full pipeline is allowed (no bubble).
- Mode switches beat-to-beat with no penalty; each beat carries its own inv.

## Test plan
- Reset then single forward beat, LANES=4, D_in=32'hFF53_0100, inv=0 -> two cycles later out_valid=1, D_out=32'h16ED_7C63, beat_cnt=1.
- Inverse beat D_in=32'h16ED_7C63, inv=1 -> D_out=32'hFF53_0100; then D_in=32'h0000_0000, inv=1 -> D_out=32'h5252_5252.
- Streaming 256 beats cycling all byte values in every lane, out_ready=1, alternating inv -> every output matches golden table, no bubbles, beat_cnt=256.
- Back-pressure: out_ready=0 while driving 3 beats -> first 2 accepted, in_ready=0 on third; raise out_ready -> outputs in order, D_out stable while stalled.
- flush with 2 beats in flight and in_valid=1 -> next cycle out_valid=0, flushed beat never emerges, beat_cnt unchanged; rst mid-stream -> all outputs return to reset values.
- INV_EN=0 build with inv=1, D_in=8'h00 (LANES=1) -> D_out=8'h63; CNT_W=4 after 17 accepts -> beat_cnt=1.
